// File: rtl/sr_latch_driver.sv
// ---------------------------------------------------------------------------
// sr_latch_driver
//
// Purpose:
//   Command stage in front of a gated SR latch. Two raw, bouncy request
//   lines (set / clear) are each synchronised, debounced and edge-detected
//   into sticky pending flags. A small FSM arbitrates the flags and drives
//   the latch s/r/e inputs with fixed-width enable pulses. It never presents
//   s=r=1.
//
// Parameters:
//   DEB_CYCLES  consecutive stable synchronised samples needed to accept a
//               level change (1..255)
//   PULSE_W     enable pulse width in clock cycles (1..15)
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst       asynchronous active-high reset
//   set_raw   raw set request (asynchronous, may bounce)
//   clr_raw   raw clear request (asynchronous, may bounce)
//   s, r, e   latch set / reset / enable, registered
//   busy      high while a command pulse or its trailing gap is in progress
//   cmd_done  one-cycle pulse in the gap cycle that ends a command
//   conflict  one-cycle pulse when simultaneous set/clear requests are dropped
//   q_est     recorded latch state after the last issued command
//
// Optional build macro:
//   SR_DRV_REDUNDANT_SUPPRESS_EN  drop lone requests that would not change
//                                 q_est (set while 1, clear while 0)
// ---------------------------------------------------------------------------
module sr_latch_driver #(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_W    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_raw,
    input  logic clr_raw,
    output logic s,
    output logic r,
    output logic e,
    output logic busy,
    output logic cmd_done,
    output logic conflict,
    output logic q_est
);

`ifdef SR_DRV_REDUNDANT_SUPPRESS_EN
    localparam logic SUPPRESS = 1'b1;
`else
    localparam logic SUPPRESS = 1'b0;
`endif

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [3:0] PW       = 4'(PULSE_W);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    // Channel 0 is the set request, channel 1 is the clear request.
    logic [1:0] w_raw;
    logic [1:0] r_sync1, r_sync2;
    logic [1:0] r_level, r_prevLevel, r_rise, r_pend;
    logic [7:0] r_debCnt [2];
    logic [1:0] w_take;
    logic       w_redundantSet, w_redundantClr;

    state_t     r_state;
    logic [3:0] r_pulseCnt;
    logic       r_s, r_r, r_e, r_busy, r_cmdDone, r_conflict, r_qEst;

    assign w_raw = {clr_raw, set_raw};

    // Two-flop synchroniser for both raw request lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: a level change is accepted only after DEB_CYCLES consecutive
    // synced samples disagree with the current level; any agreeing sample
    // restarts the count, so shorter glitches never flip the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 2'b00;
            for (int c = 0; c < 2; c++) r_debCnt[c] <= 8'd0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (r_sync2[c] == r_level[c]) begin
                    r_debCnt[c] <= 8'd0;
                end else if (r_debCnt[c] == DEB_LAST) begin
                    r_level[c]  <= ~r_level[c];
                    r_debCnt[c] <= 8'd0;
                end else begin
                    r_debCnt[c] <= r_debCnt[c] + 8'd1;
                end
            end
        end
    end

    // Any pending flag seen in IDLE is consumed that cycle: served, dropped as
    // a conflict, or dropped as redundant.
    assign w_take         = (r_state == IDLE) ? r_pend : 2'b00;
    assign w_redundantSet = SUPPRESS & r_qEst;
    assign w_redundantClr = SUPPRESS & ~r_qEst;

    // Registered rising-edge detect feeding sticky pending flags. A new edge
    // wins over a same-cycle consume so a repeat request is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prevLevel <= 2'b00;
            r_rise      <= 2'b00;
            r_pend      <= 2'b00;
        end else begin
            r_prevLevel <= r_level;
            r_rise      <= r_level & ~r_prevLevel;
            r_pend      <= (r_pend & ~w_take) | r_rise;
        end
    end

    // Command FSM. s and r are only ever loaded on the edge that raises e,
    // and are cleared together with e, so they are stable while e is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pulseCnt <= 4'd0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_e        <= 1'b0;
            r_busy     <= 1'b0;
            r_cmdDone  <= 1'b0;
            r_conflict <= 1'b0;
            r_qEst     <= 1'b0;
        end else begin
            r_cmdDone  <= 1'b0;
            r_conflict <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_pend == 2'b11) begin
                        r_conflict <= 1'b1;
                    end else if (r_pend[0] && !w_redundantSet) begin
                        r_state    <= PULSE;
                        r_s        <= 1'b1;
                        r_r        <= 1'b0;
                        r_e        <= 1'b1;
                        r_busy     <= 1'b1;
                        r_pulseCnt <= 4'd1;
                        r_qEst     <= 1'b1;
                    end else if (r_pend[1] && !w_redundantClr) begin
                        r_state    <= PULSE;
                        r_s        <= 1'b0;
                        r_r        <= 1'b1;
                        r_e        <= 1'b1;
                        r_busy     <= 1'b1;
                        r_pulseCnt <= 4'd1;
                        r_qEst     <= 1'b0;
                    end
                end
                PULSE: begin
                    if (r_pulseCnt == PW) begin
                        r_state   <= GAP;
                        r_s       <= 1'b0;
                        r_r       <= 1'b0;
                        r_e       <= 1'b0;
                        r_cmdDone <= 1'b1;
                    end else begin
                        r_pulseCnt <= r_pulseCnt + 4'd1;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_e     <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s        = r_s;
    assign r        = r_r;
    assign e        = r_e;
    assign busy     = r_busy;
    assign cmd_done = r_cmdDone;
    assign conflict = r_conflict;
    assign q_est    = r_qEst;

endmodule
